// File: rtl/present_pkg.sv
// Shared PRESENT-128 constants: S-box tables, round count, key-schedule geometry
// and FSM state encoding. Used by both the encrypt and decrypt cores.
package present_pkg;

   localparam int ROUNDS  = 31;
   localparam int KEY_ROT = 61;
   localparam int RC_LO   = 62;
   localparam int RC_HI   = 66;

   typedef logic [15:0][3:0] sbox_t;

   // Entry n sits at bits [4n+3:4n]
   localparam sbox_t SBOX     = 64'h2174_8FE3_DA09_B65C;
   localparam sbox_t INV_SBOX = 64'hA970_364B_D21C_8FE5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_ROUND
   } present_state_e;

endpackage

// File: rtl/present_decrypt_if.sv
// Load/result bus of the PRESENT decrypt core; master drives the operands,
// slave (the core) returns plaintext, completion pulse and busy.
interface present_decrypt_if;

   logic          load;
   logic [63:0]   ciphertext;
   logic [127:0]  key;
   logic [63:0]   plaintext;
   logic          load_decrypt;
   logic          busy;

   modport master (
      output load, ciphertext, key,
      input  plaintext, load_decrypt, busy
   );

   modport slave (
      input  load, ciphertext, key,
      output plaintext, load_decrypt, busy
   );

endinterface

// File: rtl/present_inv_round.sv
// One combinational PRESENT inverse round: inverse bit permutation, inverse
// S-box on all 16 nibbles, then round-key XOR.
module present_inv_round
   import present_pkg::*;
(
   input  logic [63:0] state_i,
   input  logic [63:0] rkey_i,
   output logic [63:0] state_o
);

   logic [63:0] perm;
   sbox_t       perm_n;
   sbox_t       sub_n;

   // Forward P sends bit i to 16i mod 63, so pull it back from there
   for (genvar i = 0; i < 63; i++) begin : g_perm
      assign perm[i] = state_i[(16 * i) % 63];
   end
   assign perm[63] = state_i[63];

   assign perm_n = perm;

   for (genvar n = 0; n < 16; n++) begin : g_sbox
      assign sub_n[n] = INV_SBOX[perm_n[n]];
   end

   assign state_o = sub_n ^ rkey_i;

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-128 decryption: forward key expansion to K32, then inverse
// rounds with the key schedule run backwards. Optional macro
// PRESENT_DEC_KEYCACHE_EN caches K32 per master key to skip the expansion.
module present_decrypt
   import present_pkg::*;
#(
   parameter int ROUNDS = present_pkg::ROUNDS
) (
   input logic              clk,
   input logic              rst,
   present_decrypt_if.slave bus
);

   localparam logic [5:0] KDONE = 6'(ROUNDS + 1);
   localparam logic [5:0] RLAST = 6'(ROUNDS);

   present_state_e st_q, st_d;
   logic [63:0]    ct_q, ct_d;
   logic [127:0]   key_q, key_d;
   logic [63:0]    state_q, state_d;
   logic [5:0]     kcnt_q, kcnt_d;
   logic [5:0]     rcnt_q, rcnt_d;
   logic [63:0]    pt_q, pt_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;

`ifdef PRESENT_DEC_KEYCACHE_EN
   logic [127:0]   tag_q, tag_d;
   logic [127:0]   cache_q, cache_d;
   logic           cvalid_q, cvalid_d;
`endif

   logic [127:0]   key_rot, key_fwd, key_x, key_inv;
   logic [63:0]    round_out;

   // Forward schedule step (K_i -> K_i+1) and its inverse (K_r+1 -> K_r)
   always_comb begin
      key_rot = {key_q[127-KEY_ROT:0], key_q[127:128-KEY_ROT]};
      key_fwd = key_rot;
      key_fwd[127:124] = SBOX[key_rot[127:124]];
      key_fwd[123:120] = SBOX[key_rot[123:120]];
      key_fwd[RC_HI:RC_LO] = key_rot[RC_HI:RC_LO] ^ kcnt_q[4:0];

      key_x = key_q;
      key_x[RC_HI:RC_LO] = key_q[RC_HI:RC_LO] ^ rcnt_q[4:0];
      key_x[127:124] = INV_SBOX[key_q[127:124]];
      key_x[123:120] = INV_SBOX[key_q[123:120]];
      key_inv = {key_x[KEY_ROT-1:0], key_x[127:KEY_ROT]};
   end

   present_inv_round u_round (
      .state_i (state_q),
      .rkey_i  (key_inv[127:64]),
      .state_o (round_out)
   );

   always_comb begin
      st_d    = st_q;
      ct_d    = ct_q;
      key_d   = key_q;
      state_d = state_q;
      kcnt_d  = kcnt_q;
      rcnt_d  = rcnt_q;
      pt_d    = pt_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
`ifdef PRESENT_DEC_KEYCACHE_EN
      tag_d    = tag_q;
      cache_d  = cache_q;
      cvalid_d = cvalid_q;
`endif
      unique case (st_q)
         ST_IDLE: begin
            if (bus.load) begin
               ct_d   = bus.ciphertext;
               key_d  = bus.key;
               kcnt_d = 6'd1;
               busy_d = 1'b1;
               st_d   = ST_KEYEXP;
`ifdef PRESENT_DEC_KEYCACHE_EN
               // Hit: jump straight to the final KEYEXP step with K32 in place
               if (cvalid_q && (bus.key == tag_q)) begin
                  key_d  = cache_q;
                  kcnt_d = KDONE;
               end else begin
                  tag_d    = bus.key;
                  cvalid_d = 1'b0;
               end
`endif
            end
         end
         ST_KEYEXP: begin
            if (kcnt_q == KDONE) begin
               state_d = ct_q ^ key_q[127:64];
               rcnt_d  = RLAST;
               st_d    = ST_ROUND;
`ifdef PRESENT_DEC_KEYCACHE_EN
               cache_d  = key_q;
               cvalid_d = 1'b1;
`endif
            end else begin
               key_d  = key_fwd;
               kcnt_d = kcnt_q + 6'd1;
            end
         end
         ST_ROUND: begin
            state_d = round_out;
            key_d   = key_inv;
            rcnt_d  = rcnt_q - 6'd1;
            if (rcnt_q == 6'd1) begin
               pt_d   = round_out;
               done_d = 1'b1;
               busy_d = 1'b0;
               st_d   = ST_IDLE;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= ST_IDLE;
         ct_q     <= '0;
         key_q    <= '0;
         state_q  <= '0;
         kcnt_q   <= '0;
         rcnt_q   <= '0;
         pt_q     <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef PRESENT_DEC_KEYCACHE_EN
         tag_q    <= '0;
         cache_q  <= '0;
         cvalid_q <= 1'b0;
`endif
      end else begin
         st_q     <= st_d;
         ct_q     <= ct_d;
         key_q    <= key_d;
         state_q  <= state_d;
         kcnt_q   <= kcnt_d;
         rcnt_q   <= rcnt_d;
         pt_q     <= pt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef PRESENT_DEC_KEYCACHE_EN
         tag_q    <= tag_d;
         cache_q  <= cache_d;
         cvalid_q <= cvalid_d;
`endif
      end
   end

   assign bus.plaintext    = pt_q;
   assign bus.load_decrypt = done_q;
   assign bus.busy         = busy_q;

endmodule
